vga_pixel_port: RTL and testbench

- Memory-mapped responder for the processor's VGA region, selected when realaddr[15:12]==4'h4.
- Holds the X, Y and COLOUR registers and a pixel command FIFO.
- Drains queued pixels into the framebuffer write port using a valid/ready handshake.
- Readable status lets software poll for space instead of writing blindly.

---
 rtl/vga_pixel_port.sv | 174 +++++++++++++++++
 tb/tb_vga_pixel_port.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_port.sv
// VGA region responder: X/Y/COLOUR registers, a pixel command FIFO and a
// two-state drain FSM that writes queued pixels into the framebuffer.
module vga_pixel_port #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int COLOUR_BITS = 9,
  parameter int FIFO_DEPTH  = 4,
  parameter int FB_AW       = 15
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cs,
  input  logic [3:0]             addr,
  input  logic                   W,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic [FB_AW-1:0]       fb_addr,
  output logic [COLOUR_BITS-1:0] fb_data,
  output logic                   fb_we,
  input  logic                   fb_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t                 r_state;
  logic [15:0]            r_x;
  logic [15:0]            r_y;
  logic [COLOUR_BITS-1:0] r_colour;
  logic [15:0]            r_fifo_x [FIFO_DEPTH];
  logic [15:0]            r_fifo_y [FIFO_DEPTH];
  logic [COLOUR_BITS-1:0] r_fifo_c [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_ovf;
  logic                   r_oor;

  logic        w_wr;
  logic        w_rd;
  logic        w_cmd_wr;
  logic        w_enq;
  logic        w_clr;
  logic        w_empty;
  logic        w_full;
  logic        w_in_range;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_oor_set;
  logic [31:0] w_lin;
  logic [31:0] w_status;
  logic [31:0] w_rdata_next;
  logic        w_unused;

  assign w_wr       = cs & W;
  assign w_rd       = cs & ~W;
  assign w_cmd_wr   = w_wr && (addr == 4'hC);
  assign w_enq      = w_cmd_wr & wdata[0];
  assign w_clr      = w_cmd_wr & wdata[1];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_in_range = (r_x < 16'(FB_W)) && (r_y < 16'(FB_H));
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  // A full FIFO still accepts a push when the drain pops on the same edge.
  assign w_push     = w_enq && w_in_range && (!w_full || w_pop);
  assign w_ovf_set  = w_enq && w_in_range && w_full && !w_pop;
  assign w_oor_set  = w_enq && !w_in_range;

  assign w_lin = 32'(r_fifo_y[r_rd_ptr]) * 32'(FB_W) + 32'(r_fifo_x[r_rd_ptr]);

  assign w_unused = ^{wdata[31:16], w_lin[31:FB_AW]};

  always_comb begin
    w_status     = '0;
    w_status[0]  = w_full;
    w_status[1]  = w_empty;
    w_status[6:4] = 3'(r_count);
    w_status[8]  = r_ovf;
    w_status[9]  = r_oor;
    w_status[12] = (r_state != S_IDLE) || !w_empty;
  end

  always_comb begin
    w_rdata_next = '0;
    case (addr)
      4'h0:    w_rdata_next = {16'h0, r_x};
      4'h4:    w_rdata_next = {16'h0, r_y};
      4'h8:    w_rdata_next = 32'(r_colour);
      4'hC:    w_rdata_next = w_status;
      default: w_rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      rdata    <= '0;
    end else begin
      if (w_wr && addr == 4'h0) r_x <= wdata[15:0];
      if (w_wr && addr == 4'h4) r_y <= wdata[15:0];
      if (w_wr && addr == 4'h8) r_colour <= wdata[COLOUR_BITS-1:0];
      if (w_rd) rdata <= w_rdata_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_x[r_wr_ptr] <= r_x;
      r_fifo_y[r_wr_ptr] <= r_y;
      r_fifo_c[r_wr_ptr] <= r_colour;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_oor    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Clear first so a combined clear+enqueue can re-arm a flag.
      if (w_clr) begin
        r_ovf <= 1'b0;
        r_oor <= 1'b0;
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_oor_set) r_oor <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            fb_addr <= w_lin[FB_AW-1:0];
            fb_data <= r_fifo_c[r_rd_ptr];
            fb_we   <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (fb_ready) begin
            fb_we   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          fb_we   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_port.sv
// Bench for vga_pixel_port: register/pixel vector tables plus hand-written
// back-pressure, overflow and reset sequences, with a framebuffer scoreboard.
module tb_vga_pixel_port;
  localparam int FB_W  = 160;
  localparam int FB_H  = 120;
  localparam int CB    = 9;
  localparam int DEPTH = 4;
  localparam int AW    = 15;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cs;
  logic [3:0]    addr;
  logic          W;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [AW-1:0] fb_addr;
  logic [CB-1:0] fb_data;
  logic          fb_we;
  logic          fb_ready;

  always #5 clk = ~clk;

  vga_pixel_port #(
    .FB_W(FB_W), .FB_H(FB_H), .COLOUR_BITS(CB), .FIFO_DEPTH(DEPTH), .FB_AW(AW)
  ) dut (
    .clk(clk), .resetn(resetn), .cs(cs), .addr(addr), .W(W), .wdata(wdata),
    .rdata(rdata), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .fb_ready(fb_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [AW-1:0] a; logic [CB-1:0] d; } pix_t;
  pix_t exp_q[$];

  typedef struct { logic [3:0] a; logic [31:0] wd; logic [31:0] exp; } reg_vec_t;
  typedef struct { int x; int y; logic [CB-1:0] c; logic [AW-1:0] a; } pix_vec_t;
  reg_vec_t rv[6];
  pix_vec_t pv[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accepted framebuffer writes are popped from the scoreboard in order.
  always @(negedge clk) begin : mon
    pix_t e;
    if (resetn === 1'b1 && fb_we === 1'b1 && fb_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_fb_addr", 32'(fb_addr), 32'(e.a));
        check("sb_fb_data", 32'(fb_data), 32'(e.d));
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    cs = 1'b1; W = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 1'b0; W = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    cs = 1'b1; W = 1'b0; addr = a;
    @(posedge clk); #1;
    cs = 1'b0;
    d = rdata;
  endtask

  task automatic enqueue(input int x, input int y, input logic [CB-1:0] c,
                         input bit accept, input logic [AW-1:0] exp_a);
    bus_write(4'h0, 32'(x));
    bus_write(4'h4, 32'(y));
    bus_write(4'h8, 32'(c));
    if (accept) exp_q.push_back('{a: exp_a, d: c});
    bus_write(4'hC, 32'h1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d pixels outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;

    rv[0] = '{4'h0, 32'h0000_009F, 32'h0000_009F};
    rv[1] = '{4'h4, 32'h0000_0077, 32'h0000_0077};
    rv[2] = '{4'h8, 32'h0000_00AA, 32'h0000_00AA};
    rv[3] = '{4'h0, 32'hDEAD_BEEF, 32'h0000_BEEF};
    rv[4] = '{4'h8, 32'hFFFF_FFFF, 32'h0000_01FF};
    rv[5] = '{4'h2, 32'h0000_1234, 32'h0000_0000};

    pv[0] = '{0,   0,   9'h001, 15'd0};
    pv[1] = '{159, 119, 9'h155, 15'd19199};
    pv[2] = '{159, 0,   9'h0F0, 15'd159};
    pv[3] = '{0,   119, 9'h10F, 15'd19040};
    pv[4] = '{17,  33,  9'h0AA, 15'd5297};
    pv[5] = '{100, 60,  9'h1FE, 15'd9700};

    cs = 1'b0; W = 1'b0; addr = '0; wdata = '0; fb_ready = 1'b1; resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_fb_we", 32'(fb_we), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_fb_addr", 32'(fb_addr), 32'h0);
    check("reset_fb_data", 32'(fb_data), 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    bus_read(4'hC, rd);
    check("reset_status", rd, 32'h0000_0002);

    // basic write with latency checks
    bus_write(4'h0, 32'd5);
    bus_write(4'h4, 32'd2);
    bus_write(4'h8, 32'h1FF);
    exp_q.push_back('{a: 15'd325, d: 9'h1FF});
    bus_write(4'hC, 32'h1);
    check("lat_we_n0", 32'(fb_we), 32'h0);
    @(posedge clk); #1;
    check("lat_we_n1", 32'(fb_we), 32'h1);
    check("lat_addr_n1", 32'(fb_addr), 32'd325);
    check("lat_data_n1", 32'(fb_data), 32'h1FF);
    @(posedge clk); #1;
    check("lat_we_n2", 32'(fb_we), 32'h0);
    bus_read(4'hC, rd);
    check("basic_status", rd, 32'h0000_0002);
    drain("basic");

    // register readback vectors, with rdata hold after the read
    for (int i = 0; i < 6; i++) begin
      bus_write(rv[i].a, rv[i].wd);
      bus_read(rv[i].a, rd);
      check($sformatf("readback_%0d", i), rd, rv[i].exp);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("rdata_hold_%0d", i), rdata, rv[i].exp);
    end

    // pixel vectors including the framebuffer corners
    for (int i = 0; i < 6; i++)
      enqueue(pv[i].x, pv[i].y, pv[i].c, 1'b1, pv[i].a);
    drain("pixvec");
    bus_read(4'hC, rd);
    check("pixvec_status", rd, 32'h0000_0002);

    // range checks and sticky clear
    enqueue(160, 0, 9'h011, 1'b0, 15'd0);
    drain("oor_x");
    bus_read(4'hC, rd);
    check("oor_x_status", rd, 32'h0000_0202);
    bus_write(4'hC, 32'h2);
    bus_read(4'hC, rd);
    check("oor_clear_status", rd, 32'h0000_0002);
    enqueue(0, 120, 9'h022, 1'b0, 15'd0);
    bus_write(4'hC, 32'h3);
    drain("oor_y");
    bus_read(4'hC, rd);
    check("oor_y_clr_set_status", rd, 32'h0000_0202);
    bus_write(4'hC, 32'h2);

    // overflow under back-pressure
    fb_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      enqueue(i, 0, 9'(9'h010 + i), (i < 5), 15'(i));
    bus_read(4'hC, rd);
    check("ovf_status", rd, 32'h0000_1141);
    check("ovf_we_held", 32'(fb_we), 32'h1);
    check("ovf_addr_held", 32'(fb_addr), 32'd0);
    fb_ready = 1'b1;
    drain("ovf");
    bus_read(4'hC, rd);
    check("ovf_sticky_status", rd, 32'h0000_0102);
    bus_write(4'hC, 32'h2);
    bus_read(4'hC, rd);
    check("ovf_clear_status", rd, 32'h0000_0002);

    // full FIFO with push on the same edge as the drain pop
    fb_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      enqueue(10 + i, 1, 9'(9'h020 + i), 1'b1, 15'(170 + i));
    bus_read(4'hC, rd);
    check("full_pre_status", rd, 32'h0000_1041);
    bus_write(4'h0, 32'd15);
    bus_write(4'h8, 32'h1AB);
    exp_q.push_back('{a: 15'd175, d: 9'h1AB});
    fb_ready = 1'b1;
    @(posedge clk); #1;
    fb_ready = 1'b0;
    bus_write(4'hC, 32'h1);
    bus_read(4'hC, rd);
    check("full_pushpop_status", rd, 32'h0000_1041);
    check("full_pushpop_addr", 32'(fb_addr), 32'd171);
    fb_ready = 1'b1;
    drain("full_pushpop");
    bus_read(4'hC, rd);
    check("full_pushpop_end", rd, 32'h0000_0002);

    // asynchronous reset in the middle of a stalled drain
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      enqueue(40 + i, 3, 9'(9'h030 + i), 1'b0, 15'd0);
    check("rst_pre_we", 32'(fb_we), 32'h1);
    resetn = 1'b0;
    #1;
    check("rst_async_we", 32'(fb_we), 32'h0);
    check("rst_async_rdata", rdata, 32'h0);
    check("rst_async_addr", 32'(fb_addr), 32'h0);
    #1;
    resetn = 1'b1;
    fb_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_post_we", 32'(fb_we), 32'h0);
    bus_read(4'hC, rd);
    check("rst_post_status", rd, 32'h0000_0002);
    bus_read(4'h0, rd);
    check("rst_post_x", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
